ex_mem_stage: RTL

EX/MEM pipeline stage of the MIPS core, directly downstream of the ALU. It captures each executed instruction's ALU result, carry flag, store data, destination register and memory/writeback controls, and presents them to the memory stage through a valid/ready handshake. A two-entry skid buffer lets the ALU side see a registered ready, so memory back-pressure never forms a combinational path into EX. It also drives the EX/MEM forwarding bus.

---
 rtl/ex_mem_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer, so the ready seen by EX is registered.
// Also drives the EX/MEM forwarding bus.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              carry_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic              mem_carry,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd_addr,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic              carry;
    logic [DATA_W-1:0] sdata;
    logic [REG_AW-1:0] rd;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
  } payload_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

  state_e   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  payload_t in_c;
  logic     mem_valid_q, mem_valid_d;
  logic     ex_ready_q, ex_ready_d;
  logic     fwd_valid_q, fwd_valid_d;
  logic     accept_c, retire_c;

  assign in_c = '{alu: alu_out, carry: carry_out, sdata: store_data, rd: rd_addr,
                  mem_read: mem_read, mem_write: mem_write,
                  reg_write: reg_write, mem_to_reg: mem_to_reg};

  // Next-state and entry-load logic; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    accept_c    = ex_valid & ex_ready_q;
    retire_c    = mem_valid_q & mem_ready;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d = ST_FULL;
          main_d  = in_c;
        end
      end
      ST_FULL: begin
        if (accept_c && retire_c) begin
          main_d = in_c;
        end else if (accept_c) begin
          state_d = ST_SKID;
          skid_d  = in_c;
        end else if (retire_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (retire_c) begin
          state_d = ST_FULL;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
    mem_valid_d = (state_d != ST_EMPTY);
    ex_ready_d  = (state_d != ST_SKID);
    fwd_valid_d = mem_valid_d & main_d.reg_write & ~main_d.mem_read & (main_d.rd != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      mem_valid_q <= 1'b0;
      ex_ready_q  <= 1'b1;
      fwd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      mem_valid_q <= mem_valid_d;
      ex_ready_q  <= ex_ready_d;
      fwd_valid_q <= fwd_valid_d;
    end
  end

  assign ex_ready       = ex_ready_q;
  assign mem_valid      = mem_valid_q;
  assign mem_alu_result = main_q.alu;
  assign mem_carry      = main_q.carry;
  assign mem_store_data = main_q.sdata;
  assign mem_rd_addr    = main_q.rd;
  assign mem_mem_read   = main_q.mem_read;
  assign mem_mem_write  = main_q.mem_write;
  assign mem_reg_write  = main_q.reg_write;
  assign mem_mem_to_reg = main_q.mem_to_reg;
  assign fwd_valid      = fwd_valid_q;
  assign fwd_rd         = main_q.rd;
  assign fwd_data       = main_q.alu;

endmodule
